// File: rtl/mem_bank_rw_arbiter.sv
// Read/write requester arbiter for one SRAM bank: lock-in on stalls, bounded-burst fairness,
// and a 1-bit route FIFO that steers each rvalid back to its issuer. Optional: MEM_BANK_RW_ARB_PERF_EN.
module mem_bank_rw_arbiter #(
  parameter int   AddrWidth = 32,
  parameter int   DataWidth = 32,
  parameter int   BufDepth  = 1,
  parameter int   MaxBurst  = 4,
  parameter logic WritePrio = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           r_req_i,
  input  logic                           w_req_i,
  output logic                           r_gnt_o,
  output logic                           w_gnt_o,
  input  logic [AddrWidth-1:0]           r_addr_i,
  input  logic [AddrWidth-1:0]           w_addr_i,
  input  logic [DataWidth-1:0]           r_wdata_i,
  input  logic [DataWidth-1:0]           w_wdata_i,
  input  logic [DataWidth/8-1:0]         r_strb_i,
  input  logic [DataWidth/8-1:0]         w_strb_i,
  input  logic                           r_we_i,
  input  logic                           w_we_i,
  input  logic [5:0]                     r_atop_i,
  input  logic [5:0]                     w_atop_i,
  output logic                           r_rvalid_o,
  output logic                           w_rvalid_o,
  output logic [DataWidth-1:0]           r_rdata_o,
  output logic [DataWidth-1:0]           w_rdata_o,
  output logic                           mem_req_o,
  input  logic                           mem_gnt_i,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth/8-1:0]         mem_strb_o,
  output logic                           mem_we_o,
  output logic [5:0]                     mem_atop_o,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic [$clog2(BufDepth+1)-1:0]  outstanding_o,
  output logic                           err_o,
  output logic [15:0]                    conflict_cnt_o
);

  localparam int CntWidth   = $clog2(BufDepth+1);
  localparam int BurstWidth = $clog2(MaxBurst+1);

  logic                  lock_q, lock_d, sel_q, sel_d;
  logic                  pref_q, pref_d, last_q, last_d;
  logic [BurstWidth-1:0] burst_q, burst_d, burst_inc;
  logic [BufDepth-1:0]   fifo_q, fifo_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d, wr_idx;
  logic                  err_q, err_d;
  logic                  sel, full, empty, grant, pop, other_req;

  // sel: 1 = read side, 0 = write side
  always_comb begin
    sel = pref_q;
    if (lock_q)                  sel = sel_q;
    else if (r_req_i && !w_req_i) sel = 1'b1;
    else if (w_req_i && !r_req_i) sel = 1'b0;
  end

  assign full      = (cnt_q == CntWidth'(BufDepth));
  assign empty     = (cnt_q == '0);
  assign mem_req_o = (r_req_i | w_req_i) & ~full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign r_gnt_o   = grant & sel;
  assign w_gnt_o   = grant & ~sel;

  assign mem_addr_o  = sel ? r_addr_i  : w_addr_i;
  assign mem_wdata_o = sel ? r_wdata_i : w_wdata_i;
  assign mem_strb_o  = sel ? r_strb_i  : w_strb_i;
  assign mem_we_o    = sel ? r_we_i    : w_we_i;
  assign mem_atop_o  = sel ? r_atop_i  : w_atop_i;

  assign pop        = mem_rvalid_i & ~empty;
  assign r_rvalid_o = pop & fifo_q[0];
  assign w_rvalid_o = pop & ~fifo_q[0];
  assign r_rdata_o  = mem_rdata_i;
  assign w_rdata_o  = mem_rdata_i;

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    lock_d = lock_q;
    sel_d  = sel_q;
    if (mem_req_o && !mem_gnt_i) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end else if (grant) begin
      lock_d = 1'b0;
    end
  end

  // Fairness: count consecutive contended grants to one side, flip preference at MaxBurst
  assign other_req = sel ? w_req_i : r_req_i;
  assign burst_inc = (sel == last_q) ? burst_q + 1'b1 : BurstWidth'(1);

  always_comb begin
    pref_d  = pref_q;
    burst_d = burst_q;
    last_d  = last_q;
    if (grant) begin
      last_d = sel;
      if (other_req) begin
        if (burst_inc == BurstWidth'(MaxBurst)) begin
          pref_d  = ~sel;
          burst_d = '0;
        end else begin
          burst_d = burst_inc;
        end
      end else begin
        burst_d = '0;
      end
    end
  end

  // Route FIFO kept as a shift register with the head at index 0
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (pop) begin
      for (int i = 0; i < BufDepth-1; i++) fifo_d[i] = fifo_q[i+1];
      cnt_d = cnt_q - 1'b1;
    end
    wr_idx = cnt_d;
    if (grant) begin
      for (int i = 0; i < BufDepth; i++)
        if (CntWidth'(i) == wr_idx) fifo_d[i] = sel;
      cnt_d = cnt_d + 1'b1;
    end
  end

  assign err_d = err_q | (mem_rvalid_i & empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      sel_q   <= 1'b0;
      pref_q  <= ~WritePrio;
      last_q  <= 1'b0;
      burst_q <= '0;
      fifo_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      sel_q   <= sel_d;
      pref_q  <= pref_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      fifo_q  <= fifo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_BANK_RW_ARB_PERF_EN
  logic [15:0] conf_q, conf_d;

  always_comb begin
    conf_d = conf_q;
    if (r_req_i && w_req_i && conf_q != 16'hFFFF) conf_d = conf_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conf_q <= '0;
    else         conf_q <= conf_d;
  end

  assign conflict_cnt_o = conf_q;
`else
  assign conflict_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_mem_bank_rw_arbiter.sv
// Randomized + directed bench for mem_bank_rw_arbiter against a queue-based reference model.
module tb_mem_bank_rw_arbiter;
  localparam int BUF  = 2;
  localparam int MAXB = 4;

  logic        clk_i = 1'b0, rst_ni;
  logic        r_req_i, w_req_i, r_gnt_o, w_gnt_o;
  logic [31:0] r_addr_i, w_addr_i, r_wdata_i, w_wdata_i;
  logic [3:0]  r_strb_i, w_strb_i;
  logic        r_we_i, w_we_i;
  logic [5:0]  r_atop_i, w_atop_i;
  logic        r_rvalid_o, w_rvalid_o;
  logic [31:0] r_rdata_o, w_rdata_o;
  logic        mem_req_o, mem_gnt_i;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_strb_o;
  logic        mem_we_o;
  logic [5:0]  mem_atop_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        err_o;
  logic [15:0] conflict_cnt_o;

  mem_bank_rw_arbiter #(.AddrWidth(32), .DataWidth(32), .BufDepth(BUF), .MaxBurst(MAXB),
                        .WritePrio(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .r_req_i(r_req_i), .w_req_i(w_req_i), .r_gnt_o(r_gnt_o), .w_gnt_o(w_gnt_o),
    .r_addr_i(r_addr_i), .w_addr_i(w_addr_i), .r_wdata_i(r_wdata_i), .w_wdata_i(w_wdata_i),
    .r_strb_i(r_strb_i), .w_strb_i(w_strb_i), .r_we_i(r_we_i), .w_we_i(w_we_i),
    .r_atop_i(r_atop_i), .w_atop_i(w_atop_i),
    .r_rvalid_o(r_rvalid_o), .w_rvalid_o(w_rvalid_o), .r_rdata_o(r_rdata_o), .w_rdata_o(w_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o),
    .mem_atop_o(mem_atop_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  // Reference model state: route order as a queue of issuing sides (1 = read)
  bit m_q[$];
  bit m_lock, m_lsel, m_pref, m_last, m_err;
  int m_burst, m_conf;
  bit g_r, g_w, g_mreq;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = 0; m_lsel = 0; m_pref = 1'b0; m_last = 0; m_err = 0;
    m_burst = 0; m_conf = 0;
  endtask

  // Drive one cycle, check all outputs against the model, advance the model, then clock.
  task automatic step(input bit r, input bit w, input bit mg, input bit rv);
    bit s, full, mreq, gnt, rrv, wrv;
    int n;
    r_req_i = r; w_req_i = w; mem_gnt_i = mg; mem_rvalid_i = rv; mem_rdata_i = $urandom;
    #1;
    full = (m_q.size() >= BUF);
    if (m_lock)      s = m_lsel;
    else if (r && !w) s = 1;
    else if (w && !r) s = 0;
    else             s = m_pref;
    mreq = (r || w) && !full;
    gnt  = mreq && mg;
    rrv  = rv && m_q.size() > 0 && m_q[0];
    wrv  = rv && m_q.size() > 0 && !m_q[0];
    chk("mem_req", mem_req_o, mreq);
    chk("r_gnt", r_gnt_o, gnt && s);
    chk("w_gnt", w_gnt_o, gnt && !s);
    chk("r_rvalid", r_rvalid_o, rrv);
    chk("w_rvalid", w_rvalid_o, wrv);
    chk("outstanding", outstanding_o, m_q.size());
    chk("err", err_o, m_err);
    chk("rdata", {r_rdata_o, w_rdata_o}, {mem_rdata_i, mem_rdata_i});
`ifdef MEM_BANK_RW_ARB_PERF_EN
    chk("conflict", conflict_cnt_o, m_conf);
`else
    chk("conflict", conflict_cnt_o, 0);
`endif
    if (mreq) begin
      chk("addr", mem_addr_o, s ? r_addr_i : w_addr_i);
      chk("wdata", mem_wdata_o, s ? r_wdata_i : w_wdata_i);
      chk("strb_we_atop", {mem_strb_o, mem_we_o, mem_atop_o},
          s ? {r_strb_i, r_we_i, r_atop_i} : {w_strb_i, w_we_i, w_atop_i});
    end
    g_r = gnt && s; g_w = gnt && !s; g_mreq = mreq;
    if (mreq && !mg) begin m_lock = 1; m_lsel = s; end
    else if (gnt) m_lock = 0;
    if (gnt) begin
      if (s ? w : r) begin
        n = (s == m_last) ? m_burst + 1 : 1;
        if (n == MAXB) begin m_pref = !s; m_burst = 0; end
        else m_burst = n;
      end else m_burst = 0;
      m_last = s;
    end
    if (rv && m_q.size() > 0) void'(m_q.pop_front());
    else if (rv) m_err = 1;
    if (gnt) m_q.push_back(s);
    if (r && w && m_conf < 65535) m_conf++;
    @(posedge clk_i); #2;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && m_q.size() > 0; k++) step(0, 0, 0, 1);
    chk("drained", outstanding_o, 0);
  endtask

  initial begin
    logic [8:0] order;
    bit rp, wp;
    rst_ni = 0;
    r_req_i = 0; w_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    r_addr_i = 32'h1000; w_addr_i = 32'h2000; r_wdata_i = 0; w_wdata_i = 32'hA5A5;
    r_strb_i = 4'hF; w_strb_i = 4'h3; r_we_i = 0; w_we_i = 1; r_atop_i = 0; w_atop_i = 6'h5;
    model_reset();
    #1;
    chk("rst_out", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req_gnt", {mem_req_o, r_gnt_o, w_gnt_o}, 3'b000);
    chk("rst_rvalid", {r_rvalid_o, w_rvalid_o}, 2'b00);
    chk("rst_conf", conflict_cnt_o, 0);
    #11 rst_ni = 1;
    @(posedge clk_i); #2;

    // Continuous contention: expect W,W,W,W,R,R,R,R,W
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 1, m_q.size() > 0);
      order[i] = g_r;
    end
    chk("order", order, 9'b0_1111_0000);
    drain();

    // Read stalls 3 cycles; write arrives while preferred but lock holds the read
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("lock_rgnt", g_r, 1);
    step(0, 1, 1, 1);
    chk("lock_wfollow", g_w, 1);
    drain();

    // Write-only streaming with rvalid one cycle behind
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, m_q.size() > 0);
      chk("wo_gnt", g_w, 1);
    end
    drain();

    // Fill the FIFO: full blocks, a pop cycle still blocks, next cycle grants
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("full_noreq", g_mreq, 0);
    step(0, 1, 1, 1);
    chk("pop_nogrant", g_w, 0);
    step(0, 1, 1, 0);
    chk("after_pop_grant", g_w, 1);
    drain();

    // Randomized traffic honouring hold-until-granted
    rp = 0; wp = 0;
    for (int c = 0; c < 400; c++) begin
      if (!rp) begin
        rp = ($urandom % 3) != 0;
        r_addr_i = $urandom; r_wdata_i = $urandom; r_strb_i = 4'($urandom);
        r_we_i = 1'($urandom); r_atop_i = 6'($urandom);
      end
      if (!wp) begin
        wp = ($urandom % 3) != 0;
        w_addr_i = $urandom; w_wdata_i = $urandom; w_strb_i = 4'($urandom);
        w_we_i = 1'($urandom); w_atop_i = 6'($urandom);
      end
      step(rp, wp, ($urandom % 4) != 0, m_q.size() > 0 && ($urandom % 2) == 1);
      if (g_r) rp = 0;
      if (g_w) wp = 0;
    end
    drain();

    // Stray rvalid: sticky error, nothing routed
    step(0, 0, 0, 1);
    chk("err_set", err_o, 1);
    step(0, 0, 0, 0);
    chk("err_sticky", err_o, 1);

    // Async reset mid-operation discards routing
    step(0, 1, 1, 0);
    chk("pre_rst_out", outstanding_o, 1);
    r_req_i = 0; w_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    rst_ni = 0;
    #1;
    chk("async_err", err_o, 0);
    chk("async_out", outstanding_o, 0);
    model_reset();
    #1 rst_ni = 1;
    @(posedge clk_i); #2;
    step(0, 0, 0, 1);
    chk("post_rst_err", err_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_bank_rw_arbiter.md
# mem_bank_rw_arbiter

Per-bank arbiter that shares one memory bank port between a read-side and a write-side memory requester. It sits between the split read/write AXI-to-memory converters and a single SRAM bank. It provides lock-in on stalled requests, a bounded-burst fairness policy and a response-routing FIFO that returns each `rvalid` to the requester that issued it. One instance is placed per bank.

## Interface

- `AddrWidth`, 32: memory byte-address width.
- `DataWidth`, 32: bank data width; multiple of 8.
- `BufDepth`, 1: maximum outstanding granted requests (memory latency); ≥1.
- `MaxBurst`, 4: consecutive grants to one side while the other waits before preference flips; ≥1.
- `WritePrio`, 1'b1: side preferred out of reset (1 = write, 0 = read).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `r_req_i` / `w_req_i` in 1 each: request from the read / write side.
- `r_gnt_o` / `w_gnt_o` out 1 each: grant to the read / write side.
- `r_addr_i`, `w_addr_i` in AddrWidth; `r_wdata_i`, `w_wdata_i` in DataWidth; `r_strb_i`, `w_strb_i` in DataWidth/8; `r_we_i`, `w_we_i` in 1; `r_atop_i`, `w_atop_i` in 6 (`axi_pkg::atop_t`): per-side payload.
- `r_rvalid_o` / `w_rvalid_o` out 1 each: routed response valid.
- `r_rdata_o` / `w_rdata_o` out DataWidth each: `mem_rdata_i` fanned out to both sides.
- `mem_req_o` out 1; `mem_gnt_i` in 1: bank request/grant.
- `mem_addr_o`, `mem_wdata_o`, `mem_strb_o`, `mem_we_o`, `mem_atop_o` out: selected payload.
- `mem_rvalid_i` in 1; `mem_rdata_i` in DataWidth: bank response.
- `outstanding_o` out $clog2(BufDepth+1): granted requests awaiting `rvalid`.
- `err_o` out 1: sticky; set when `rvalid` arrives with nothing outstanding.
- `conflict_cnt_o` out 16: cycles in which both sides requested.

## Operation

- Selection `sel` (0 = write, 1 = read):
  - Locked: if `lock_q`, `sel = sel_q`.
  - Else if only one side requests, that side is selected.
  - Else if both request, the side given by `pref_q` is selected.
- `mem_req_o = (r_req_i|w_req_i) & !full`. The payload mux follows `sel`. `r_gnt_o = mem_gnt_i & mem_req_o & sel`; `w_gnt_o` uses `!sel`.
- Lock-in: when `mem_req_o & !mem_gnt_i`, set `lock_q` and store `sel_q = sel`. Clear `lock_q` on grant. Requesters must hold `req`/payload until granted. Lock persists even if the other side has priority.
- Fairness counter `burst_q` (width $clog2(MaxBurst+1)):
  - On grant with the other side requesting, increment if same side as the last grant, else load 1.
  - When the count reaches MaxBurst, `pref_q` flips to the other side and the counter clears.
  - Grant without contention: counter clears, `pref_q` unchanged.
- Route FIFO: depth BufDepth, 1 bit wide.
  - Push `sel` on `mem_req_o & mem_gnt_i`. Pop on `mem_rvalid_i`.
  - `r_rvalid_o = mem_rvalid_i & !empty & head`; `w_rvalid_o = mem_rvalid_i & !empty & !head`.
- Full: `mem_req_o` = 0 and no grants. A pop in the same cycle does not unblock (no bypass).
- Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
- `mem_rvalid_i` while empty: both rvalid outputs 0, no pop, `err_o` set.

## Timing

- Request-to-bank path is combinational: 0-cycle latency from `*_req_i` to `mem_req_o` and from `mem_gnt_i` to `*_gnt_o`.
- Response routing is combinational from `mem_rvalid_i` and the FIFO head.
- State updates occur on `clk_i` rising edge: `lock_q`, `sel_q`, `pref_q`, `burst_q`, FIFO, `err_o`, counter.
- Reset values:
  - `lock_q` = 0, `sel_q` = 0, `pref_q` = !WritePrio, `burst_q` = 0.
  - FIFO empty; `outstanding_o` = 0; `err_o` = 0; `conflict_cnt_o` = 0.
  - With no requests and no `rvalid`, all grant, request and rvalid outputs are 0.
- Reset mid-operation discards the lock and outstanding routing. Responses arriving afterwards raise `err_o` and are not routed.

## Configuration

- `MEM_BANK_RW_ARB_PERF_EN` defined: `conflict_cnt_o` is a 16-bit saturating counter. It increments every cycle with `r_req_i & w_req_i`, holds at 16'hFFFF and clears only on reset.
- Not defined: no counter flops are implemented and `conflict_cnt_o` is tied to 16'h0.
- All other behaviour is identical in both builds.

## Test plan

- Write-only traffic, BufDepth=2, `mem_gnt_i`=1, `rvalid` 1 cycle after grant: `w_gnt_o` every cycle, `w_rvalid_o` 1 cycle after each grant, `r_rvalid_o` never set.
- Both sides request continuously, MaxBurst=4, WritePrio=1:
  - Grant order is W,W,W,W,R,R,R,R,W…
  - With PERF_EN, `conflict_cnt_o` counts every cycle.
- Read requested, `mem_gnt_i`=0 for 3 cycles, write asserted in cycle 1 while write is preferred: `mem_addr_o` stays on the read address, `r_gnt_o` fires in cycle 3, and the write follows.
- BufDepth=1 with `rvalid` delayed 3 cycles: after one grant `mem_req_o`=0 and `outstanding_o`=1. A pop cycle does not grant; the grant comes the next cycle.
- Interleaved R,W grants with out-of-phase `rvalid`: each `rvalid` returns to its issuing side in grant order and `rdata` is seen on both sides.
- `mem_rvalid_i` pulse with nothing outstanding: `err_o`=1 sticky, no rvalid output. Assert `rst_ni` low: `err_o`=0 and `outstanding_o`=0 immediately (asynchronous).
